// File: rtl/uart_cpu_regs_pkg.sv
// Shared constants for the UART CPU register block: register map, bit positions,
// character-width codes and TX sequencer states.
package uart_cpu_regs_pkg;

    // Word addresses of the four registers
    localparam int ADDR_STAT = 0;
    localparam int ADDR_CTRL = 1;
    localparam int ADDR_TX   = 2;
    localparam int ADDR_RX   = 3;

    // CTRL register bit positions
    localparam int CTRL_TX_EN       = 0;
    localparam int CTRL_TX_START    = 1;
    localparam int CTRL_TX_WIDTH_LO = 5;
    localparam int CTRL_RX_EN       = 16;
    localparam int CTRL_RX_WIDTH_LO = 21;

    // STAT register bit positions
    localparam int STAT_TX_DONE   = 0;
    localparam int STAT_TX_BUSY   = 1;
    localparam int STAT_RX_VALID  = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_FRAME_ERR = 4;
    localparam int STAT_TX_COLL   = 5;

    // Character width encoding shared by TX and RX
    typedef enum logic [1:0] {
        WIDTH_5 = 2'b00,
        WIDTH_6 = 2'b01,
        WIDTH_7 = 2'b10,
        WIDTH_8 = 2'b11
    } width_e;

    // TX sequencer states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_BUSY  = 2'b10
    } tx_state_e;

    // Mask keeping only the data bits that a given character width transmits
    function automatic logic [7:0] width_mask(input width_e w);
        logic [7:0] m;
        case (w)
            WIDTH_5: m = 8'h1F;
            WIDTH_6: m = 8'h3F;
            WIDTH_7: m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_cpu_regs_rx_holding.sv
// RX holding register: captures bytes from the RX engine and keeps the
// valid / overrun / frame-error flags seen by the CPU through STAT.
module uart_rx_holding (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_en_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       rx_frame_err_i,
    input  logic       rd_rx_i,
    input  logic       clr_overrun_i,
    input  logic       clr_frame_err_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       overrun_o,
    output logic       frame_err_o
);

    logic capture;

    assign capture = rx_valid_i && rx_en_i;

    // Latch the incoming byte whenever the receiver is enabled and delivers one
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_byte_o <= '0;
        end else if (capture) begin
            rx_byte_o <= rx_data_i;
        end
    end

    // A fresh byte marks data valid; a CPU read of RX clears it unless a new byte lands in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_valid_o <= 1'b0;
        end else if (capture) begin
            rx_valid_o <= 1'b1;
        end else if (rd_rx_i) begin
            rx_valid_o <= 1'b0;
        end
    end

    // Overrun flags an unread byte being overwritten; a read in the same cycle counts as consumed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_o <= 1'b0;
        end else if (capture && rx_valid_o && !rd_rx_i) begin
            overrun_o <= 1'b1;
        end else if (clr_overrun_i) begin
            overrun_o <= 1'b0;
        end
    end

    // Sticky frame error from a bad stop bit; the set event beats a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_o <= 1'b0;
        end else if (capture && rx_frame_err_i) begin
            frame_err_o <= 1'b1;
        end else if (clr_frame_err_i) begin
            frame_err_o <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_cpu_regs.sv
// CPU-side register file for the UART: decodes bus cycles into STAT/CTRL/TX/RX,
// sequences the TX start pulse and busy flag, and hosts the RX holding register.
module uart_cpu_regs
    import uart_cpu_regs_pkg::*;
#(
    parameter int CPU_ADDR_WIDTH = 2,
    parameter int CPU_DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_en_cpu_i,
    input  logic                      rd_en_cpu_i,
    input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [CPU_DATA_WIDTH-1:0] cpu_wr_data_i,
    output logic [CPU_DATA_WIDTH-1:0] cpu_rd_data_o,
    output logic                      tx_en_o,
    output logic [1:0]                tx_width_o,
    output logic [7:0]                tx_data_o,
    output logic                      tx_start_o,
    input  logic                      tx_done_i,
    output logic                      rx_en_o,
    output logic [1:0]                rx_width_o,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_valid_i,
    input  logic                      rx_frame_err_i
);

    logic sel_stat, sel_ctrl, sel_tx, sel_rx;
    logic wr_stat, wr_ctrl, wr_tx, rd_rx;
    logic [7:0] tx_hold_q;
    logic tx_done_q, tx_coll_q, tx_busy;
    logic start_req, busy_eff, start_ok, collision, en_off;
    tx_state_e state_q, state_d;
    logic [7:0] rx_byte;
    logic rx_valid, overrun, frame_err;
    logic [CPU_DATA_WIDTH-1:0] stat_word, ctrl_word, rd_mux;
    logic unused_wr_bits;

    assign sel_stat = (cpu_addr_i == CPU_ADDR_WIDTH'(ADDR_STAT));
    assign sel_ctrl = (cpu_addr_i == CPU_ADDR_WIDTH'(ADDR_CTRL));
    assign sel_tx   = (cpu_addr_i == CPU_ADDR_WIDTH'(ADDR_TX));
    assign sel_rx   = (cpu_addr_i == CPU_ADDR_WIDTH'(ADDR_RX));

    assign wr_stat = wr_en_cpu_i && sel_stat;
    assign wr_ctrl = wr_en_cpu_i && sel_ctrl;
    assign wr_tx   = wr_en_cpu_i && sel_tx;
    assign rd_rx   = rd_en_cpu_i && sel_rx;

    // A done pulse in the same cycle frees the transmitter, so a back-to-back start is accepted
    assign start_req = wr_ctrl && cpu_wr_data_i[CTRL_TX_START] && cpu_wr_data_i[CTRL_TX_EN];
    assign busy_eff  = tx_busy && !tx_done_i;
    assign start_ok  = start_req && !busy_eff;
    assign collision = start_req && busy_eff;
    assign en_off    = wr_ctrl && !cpu_wr_data_i[CTRL_TX_EN];

    assign unused_wr_bits = ^{cpu_wr_data_i[15:8], cpu_wr_data_i[20:17],
                              cpu_wr_data_i[CPU_DATA_WIDTH-1:23]};

    // CTRL fields: enables and widths for both directions
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_en_o    <= 1'b0;
            tx_width_o <= 2'b00;
            rx_en_o    <= 1'b0;
            rx_width_o <= 2'b00;
        end else if (wr_ctrl) begin
            tx_en_o    <= cpu_wr_data_i[CTRL_TX_EN];
            tx_width_o <= cpu_wr_data_i[CTRL_TX_WIDTH_LO +: 2];
            rx_en_o    <= cpu_wr_data_i[CTRL_RX_EN];
            rx_width_o <= cpu_wr_data_i[CTRL_RX_WIDTH_LO +: 2];
        end
    end

    // TX holding byte, kept unmasked so software reads back what it wrote
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_hold_q <= '0;
        end else if (wr_tx) begin
            tx_hold_q <= cpu_wr_data_i[7:0];
        end
    end

    assign tx_data_o = tx_hold_q & width_mask(width_e'(tx_width_o));

    // TX sequencer state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // TX sequencer next state: disabling TX aborts from anywhere, a valid start re-enters START
    always_comb begin
        state_d = state_q;
        if (en_off) begin
            state_d = TX_IDLE;
        end else if (start_ok) begin
            state_d = TX_START;
        end else begin
            case (state_q)
                TX_START: state_d = tx_done_i ? TX_IDLE : TX_BUSY;
                TX_BUSY:  state_d = tx_done_i ? TX_IDLE : TX_BUSY;
                default:  state_d = TX_IDLE;
            endcase
        end
    end

    // TX sequencer outputs: the start pulse lasts exactly the START state, busy covers START and BUSY
    always_comb begin
        tx_start_o = 1'b0;
        tx_busy    = 1'b0;
        case (state_q)
            TX_START: begin
                tx_start_o = 1'b1;
                tx_busy    = 1'b1;
            end
            TX_BUSY:  tx_busy = 1'b1;
            default:  ;
        endcase
    end

    // Sticky TX status flags; hardware set events take priority over write-one-to-clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_done_q <= 1'b0;
            tx_coll_q <= 1'b0;
        end else begin
            if (tx_done_i) begin
                tx_done_q <= 1'b1;
            end else if (wr_stat && cpu_wr_data_i[STAT_TX_DONE]) begin
                tx_done_q <= 1'b0;
            end
            if (collision) begin
                tx_coll_q <= 1'b1;
            end else if (wr_stat && cpu_wr_data_i[STAT_TX_COLL]) begin
                tx_coll_q <= 1'b0;
            end
        end
    end

    uart_rx_holding u_rx_holding (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rx_en_i        (rx_en_o),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_frame_err_i (rx_frame_err_i),
        .rd_rx_i        (rd_rx),
        .clr_overrun_i  (wr_stat && cpu_wr_data_i[STAT_OVERRUN]),
        .clr_frame_err_i(wr_stat && cpu_wr_data_i[STAT_FRAME_ERR]),
        .rx_byte_o      (rx_byte),
        .rx_valid_o     (rx_valid),
        .overrun_o      (overrun),
        .frame_err_o    (frame_err)
    );

    // Assemble STAT and CTRL views and select the addressed register
    always_comb begin
        stat_word                 = '0;
        stat_word[STAT_TX_DONE]   = tx_done_q;
        stat_word[STAT_TX_BUSY]   = tx_busy;
        stat_word[STAT_RX_VALID]  = rx_valid;
        stat_word[STAT_OVERRUN]   = overrun;
        stat_word[STAT_FRAME_ERR] = frame_err;
        stat_word[STAT_TX_COLL]   = tx_coll_q;

        ctrl_word                                = '0;
        ctrl_word[CTRL_TX_EN]                    = tx_en_o;
        ctrl_word[CTRL_TX_WIDTH_LO +: 2]         = tx_width_o;
        ctrl_word[CTRL_RX_EN]                    = rx_en_o;
        ctrl_word[CTRL_RX_WIDTH_LO +: 2]         = rx_width_o;

        rd_mux = '0;
        if (sel_stat) begin
            rd_mux = stat_word;
        end else if (sel_ctrl) begin
            rd_mux = ctrl_word;
        end else if (sel_tx) begin
            rd_mux[7:0] = tx_hold_q;
        end else if (sel_rx) begin
            rd_mux[7:0] = rx_byte;
        end
    end

    // Registered read data, held until the next read strobe; reflects pre-write state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cpu_rd_data_o <= '0;
        end else if (rd_en_cpu_i) begin
            cpu_rd_data_o <= rd_mux;
        end
    end

endmodule
